// File: rtl/keypad_emu.sv
// Keypad emulator: one 4x4 matrix key is pressed and held, with a timed bounce phase
// before HELD and another after release. Define KEYPAD_BOUNCE_EN for LFSR-driven contact chatter.
module keypad_emu #(
    parameter int unsigned BOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r,
    input  logic [3:0] key,
    input  logic       press_req,
    input  logic       release_req,
    output logic [3:0] c,
    output logic       busy,
    output logic       held,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HELD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } state_e;

    state_e           state_q;
    logic [3:0]       key_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       press_count_q;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic             contact;

    // x^8+x^6+x^5+x^4+1, shift-left Fibonacci
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            key_q         <= 4'h0;
            cnt_q         <= '0;
            press_count_q <= 8'h00;
            lfsr_q        <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    if (press_req) begin
                        key_q   <= key;
                        cnt_q   <= CNT_LOAD;
                        state_q <= PRESS_BOUNCE;
                    end
                end
                PRESS_BOUNCE: begin
                    if (cnt_q == '0) begin
                        state_q       <= HELD;
                        press_count_q <= press_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HELD: begin
                    if (release_req) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= RELEASE_BOUNCE;
                    end
                end
                RELEASE_BOUNCE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Contact level; the final bounce cycle always settles to the target level
    always_comb begin
        contact = 1'b0;
        case (state_q)
            HELD: contact = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            PRESS_BOUNCE:   contact = (cnt_q == '0) ? 1'b1 : lfsr_q[0];
            RELEASE_BOUNCE: contact = (cnt_q == '0) ? 1'b0 : lfsr_q[0];
`else
            PRESS_BOUNCE:   contact = 1'b1;
            RELEASE_BOUNCE: contact = 1'b0;
`endif
            default: contact = 1'b0;
        endcase
    end

    always_comb begin
        c               = 4'b0000;
        c[key_q[1:0]]   = contact & r[key_q[3:2]];
    end

    assign busy        = (state_q != IDLE);
    assign held        = (state_q == HELD);
    assign press_count = press_count_q;

endmodule

// File: tb/tb_keypad_emu.sv
// Directed bench for keypad_emu with a timeline-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_keypad_emu;

    localparam int unsigned BC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] r;
    logic [3:0] key;
    logic       press_req;
    logic       release_req;
    logic [3:0] c;
    logic       busy;
    logic       held;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_err = 0;

    keypad_emu #(.BOUNCE_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .r(r), .key(key),
        .press_req(press_req), .release_req(release_req),
        .c(c), .busy(busy), .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 pressing, 2 held, 3 releasing; age = cycles spent in mode
    int         m_mode;
    int         m_age;
    logic [3:0] m_key;
    logic [7:0] m_count;
    logic [7:0] m_lfsr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_age = 0; m_key = 4'h0; m_count = 8'h00; m_lfsr = 8'hA5;
        end else begin
            case (m_mode)
                0: if (press_req) begin m_mode = 1; m_age = 0; m_key = key; end
                1: if (m_age == BC - 1) begin m_mode = 2; m_count = m_count + 8'd1; end
                   else m_age++;
                2: if (release_req) begin m_mode = 3; m_age = 0; end
                default: if (m_age == BC - 1) m_mode = 0; else m_age++;
            endcase
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic model_contact();
        logic last;
        last = (m_age == BC - 1);
        case (m_mode)
            2: return 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            1: return last ? 1'b1 : m_lfsr[0];
            3: return last ? 1'b0 : m_lfsr[0];
`else
            1: return 1'b1;
            3: return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] exp_c;
        exp_c = (model_contact() && r[m_key[3:2]]) ? (4'b0001 << m_key[1:0]) : 4'b0000;
        check("model_c", {4'h0, c}, {4'h0, exp_c});
        check("model_busy", {7'h0, busy}, {7'h0, m_mode != 0});
        check("model_held", {7'h0, held}, {7'h0, m_mode == 2});
        check("model_count", press_count, m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key = k; press_req = 1'b1;
        tick();
        press_req = 1'b0;
    endtask

    task automatic release_key();
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; r = 4'b0000; key = 4'h0; press_req = 1'b0; release_req = 1'b0;
        repeat (3) tick();
        check("reset_c", {4'h0, c}, 8'h00);
        check("reset_busy", {7'h0, busy}, 8'h00);
        check("reset_held", {7'h0, held}, 8'h00);
        check("reset_count", press_count, 8'h00);
        reset = 1'b0;
        tick();

        // Key 6, row 1 driven: column 2 closes immediately, HELD 8 edges after the press edge
        r = 4'b0010;
        press(4'h6);
        check("k6_c_first", {4'h0, c}, 8'h04);
        check("k6_busy", {7'h0, busy}, 8'h01);
        release_key();            // ignored during PRESS_BOUNCE
        repeat (6) tick();
        check("k6_held_early", {7'h0, held}, 8'h00);
        check("k6_c_bounce", {4'h0, c}, 8'h04);
        tick();
        check("k6_held", {7'h0, held}, 8'h01);
        check("k6_count", press_count, 8'h01);
        release_key();
        check("k6_rel_c", {4'h0, c}, 8'h00);
        repeat (7) tick();
        check("k6_rel_busy", {7'h0, busy}, 8'h01);
        tick();
        check("k6_idle", {7'h0, busy}, 8'h00);

        // Key F: only row 3 reaches column 3
        press(4'hF);
        repeat (BC) tick();
        for (int i = 0; i < 4; i++) begin
            r = 4'b0001 << i;
            #1;
            check("kf_sweep", {4'h0, c}, (i == 3) ? 8'h08 : 8'h00);
        end
        r = 4'b1111; #1;
        check("kf_all_rows", {4'h0, c}, 8'h08);
        release_key();
        repeat (BC) tick();

        // Second press during PRESS_BOUNCE with key 0 is ignored
        r = 4'b0010;
        press(4'h6);
        repeat (2) tick();
        press(4'h0);
        repeat (BC - 3) tick();
        check("ign_held", {7'h0, held}, 8'h01);
        check("ign_c", {4'h0, c}, 8'h04);
        check("ign_count", press_count, 8'h03);

        // Both requests in HELD: release wins
        press_req = 1'b1; release_req = 1'b1; key = 4'h0;
        tick();
        press_req = 1'b0; release_req = 1'b0;
        check("both_held_c", {4'h0, c}, 8'h00);
        check("both_held_busy", {7'h0, busy}, 8'h01);
        repeat (7) tick();
        check("both_held_busy7", {7'h0, busy}, 8'h01);
        tick();
        check("both_held_drop", {7'h0, busy}, 8'h00);

        // Both requests in IDLE: press wins with the new key
        r = 4'b0001;
        press_req = 1'b1; release_req = 1'b1; key = 4'h1;
        tick();
        press_req = 1'b0; release_req = 1'b0;
        check("both_idle_c", {4'h0, c}, 8'h02);
        repeat (BC) tick();
        check("both_idle_held", {7'h0, held}, 8'h01);
        check("both_idle_count", press_count, 8'h04);
        release_key();
        repeat (BC) tick();

        // Asynchronous reset in the middle of PRESS_BOUNCE
        reset = 1'b1; tick(); reset = 1'b0; tick();
        press(4'h6);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_c", {4'h0, c}, 8'h00);
        check("mid_rst_busy", {7'h0, busy}, 8'h00);
        check("mid_rst_count", press_count, 8'h00);
        tick();
        reset = 1'b0;
        repeat (BC + 2) tick();
        check("mid_rst_after", press_count, 8'h00);

        // 256 full press/release cycles wrap the counter
        for (int n = 0; n < 256; n++) begin
            press(n[3:0]);
            repeat (BC) tick();
            release_key();
            repeat (BC) tick();
            if (n == 254) check("wrap_255", press_count, 8'hFF);
        end
        check("wrap_0", press_count, 8'h00);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 8, sets the length in clk cycles of each bounce phase; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 r  input  4  row drive from the scanner; r[i] high means row i is driven; more than one bit may be high.
REQ-005 key  input  4  key code to press; row = key[3:2], column = key[1:0].
REQ-006 press_req  input  1  one-cycle request to start pressing key.
REQ-007 release_req  input  1  one-cycle request to release the held key.
REQ-008 c  output  4  column sense lines; c[j] high means column j is connected to a driven row.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 held  output  1  high only in state HELD.
REQ-011 press_count  output  8  number of entries into HELD since reset, modulo 256.

Function
REQ-012 The FSM SHALL have four states: IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE.
REQ-013 In IDLE, press_req=1 SHALL latch key into an internal key register and move to PRESS_BOUNCE on the same edge.
REQ-014 PRESS_BOUNCE SHALL last exactly BOUNCE_CYCLES cycles, then move to HELD.
REQ-015 In HELD, release_req=1 SHALL move to RELEASE_BOUNCE on the same edge.
REQ-016 RELEASE_BOUNCE SHALL last exactly BOUNCE_CYCLES cycles, then move to IDLE.
REQ-017 Internal contact SHALL be 0 in IDLE, 1 in HELD, and as defined in REQ-030/031 in the bounce states.
REQ-018 c[j] SHALL equal contact AND r[key_row] AND (j == key_col); the path from r to c is combinational, and all other c bits are 0.
REQ-019 press_req outside IDLE SHALL be ignored, and key SHALL NOT be re-latched.
REQ-020 release_req outside HELD SHALL be ignored, including a release that arrives during PRESS_BOUNCE.
REQ-021 If press_req and release_req are both 1 in IDLE, the press SHALL be taken.
REQ-022 If press_req and release_req are both 1 in HELD, the release SHALL be taken.
REQ-023 The bounce counter SHALL be 8 bits, loaded with BOUNCE_CYCLES-1 on entry to a bounce state, and decremented each cycle; the exit occurs when it is 0.
REQ-024 press_count SHALL increment on each PRESS_BOUNCE->HELD transition and wrap from 255 to 0.
REQ-025 An 8-bit LFSR SHALL advance every cycle, using polynomial x^8+x^6+x^5+x^4+1 with a shift-left Fibonacci form.

Reset
REQ-026 When reset is asserted, state SHALL go to IDLE, contact to 0, the key register to 0, the bounce counter to 0, press_count to 0, and the LFSR to 8'hA5.
REQ-027 While reset is high, c, busy and held SHALL be 0 with no clock edge required.
REQ-028 A reset during any bounce or HELD state SHALL abandon the operation; no press_count increment occurs.
REQ-029 After reset deasserts, the first accepted press_req SHALL be on the first rising edge with press_req=1.

Configuration
REQ-030 With KEYPAD_BOUNCE_EN defined, contact in both bounce states SHALL equal LFSR bit 0, except that it SHALL be forced to 1 in the final PRESS_BOUNCE cycle and 0 in the final RELEASE_BOUNCE cycle.
REQ-031 Without KEYPAD_BOUNCE_EN, contact SHALL be 1 throughout PRESS_BOUNCE and 0 throughout RELEASE_BOUNCE (clean edges); state timing is unchanged.

Verification
REQ-032 No macro, BOUNCE_CYCLES=8, key=4'h6 pressed at cycle 0, r=4'b0010 held:
- c=4'b0100 from cycle 1 onward.
- held rises at cycle 9.
- press_count=1.
REQ-033 Press key=4'hF with r sweeping one-hot 0001/0010/0100/1000 while HELD -> c=4'b1000 only when r=4'b1000, otherwise 0; with r=4'b1111, c=4'b1000.
REQ-034 press_req at cycle 3 of PRESS_BOUNCE with key=4'h0 -> ignored; the latched key is unchanged, and HELD is reached on schedule.
REQ-035 press_req and release_req both 1:
- In HELD, this enters RELEASE_BOUNCE, and busy drops 8 cycles later.
- In IDLE, this enters PRESS_BOUNCE.
REQ-036 Reset asserted mid-PRESS_BOUNCE -> c=0, busy=0 immediately; press_count stays 0. 256 full press/release cycles -> press_count=0.
REQ-037 KEYPAD_BOUNCE_EN defined, BOUNCE_CYCLES=8, LFSR seed 8'hA5 -> c chatters per LFSR bit 0, c=1 in the last PRESS_BOUNCE cycle, and c=0 in the last RELEASE_BOUNCE cycle.
